// File: rtl/alu_div_pkg.sv
// Shared definitions for the divider scheduler: FSM state type, default width, divider latency.
package alu_div_pkg;

    localparam int W_DEFAULT = 8;
    // Latency of the 8-bit non_rest_div from start to done; the scheduler itself does not depend on it.
    localparam int DIV_LAT   = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_div_sched_if.sv
// Requester-side request/response channels of the divider scheduler.
interface alu_div_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [NUM_REQ-1:0]   resp_ready;
    logic [2*W-1:0]       resp_quotient;
    logic [2*W-1:0]       resp_remainder;
    logic                 resp_dbz;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_quotient, resp_remainder, resp_dbz
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_quotient, resp_remainder, resp_dbz
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int unsigned k;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        k         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(ptr) + i) % N;
            if (!any && req[k]) begin
                any       = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IW'(k);
            end
        end
    end

endmodule

// File: rtl/alu_div_sched.sv
// Round-robin scheduler sharing one sequential signed divider among NUM_REQ requesters.
// Optional feature: define ALU_DIV_ZERO_BYPASS_EN to answer b == 0 without starting the divider.
module alu_div_sched
    import alu_div_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_div_sched_if.slave       bus,
    output logic                 div_reset,
    output logic                 div_start,
    output logic [W-1:0]         div_a,
    output logic [W-1:0]         div_b,
    input  logic                 div_done,
    input  logic [2*W-1:0]       div_quotient,
    input  logic [2*W-1:0]       div_remainder
);

    localparam int IW = $clog2(NUM_REQ);

`ifdef ALU_DIV_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   gnt_idx_q;
    logic [W-1:0]    a_q, b_q;
    logic [2*W-1:0]  quot_q, rem_q;
    logic            dbz_q;
    logic            div_reset_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic [W-1:0]       sel_a, sel_b;
    logic               accept, bypass_hit, done_take, resp_hs;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign sel_a      = bus.req_a[32'(arb_idx) * W +: W];
    assign sel_b      = bus.req_b[32'(arb_idx) * W +: W];
    // No grant while the divider is still being cleared after reset.
    assign accept     = (state_q == ST_IDLE) && !div_reset_q && arb_any;
    assign bypass_hit = BYPASS && (sel_b == '0);
    assign done_take  = (state_q == ST_WAIT) && div_done;
    assign resp_hs    = (state_q == ST_RESP) && bus.resp_ready[gnt_idx_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        div_start      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    bus.req_ready = arb_grant;
                    state_d       = bypass_hit ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                div_start = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done) state_d = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = NUM_REQ'(1) << gnt_idx_q;
                if (bus.resp_ready[gnt_idx_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_reset_q <= 1'b1;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
        end else begin
            div_reset_q <= 1'b0;
            if (accept) begin
                a_q       <= sel_a;
                b_q       <= sel_b;
                gnt_idx_q <= arb_idx;
                if (bypass_hit) begin
                    quot_q <= '0;
                    rem_q  <= '0;
                    dbz_q  <= 1'b1;
                end
            end
            if (done_take) begin
                quot_q <= div_quotient;
                rem_q  <= div_remainder;
                dbz_q  <= (b_q == '0);
            end
            if (resp_hs) begin
                rr_ptr_q <= (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IW'(1);
            end
        end
    end

    assign div_reset          = div_reset_q;
    assign div_a              = a_q;
    assign div_b              = b_q;
    assign bus.resp_quotient  = quot_q;
    assign bus.resp_remainder = rem_q;
    assign bus.resp_dbz       = dbz_q;

endmodule
